// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder: extended-Hamming SECDED decoder with a valid/ready stream and a one-entry output register
//
// Ports
//    clk            clock
//    rst_n          asynchronous active-low reset
//    ena            block enable; low freezes accepts and counters (a held result may still be popped)
//    correct_en     1 = correct single errors, 0 = detect only
//    cnt_clr        synchronous clear of both error counters (wins over a same-cycle count)
//    in_valid       codeword valid
//    in_ready       decoder can accept a codeword
//    in_code        received codeword; bit i-1 is Hamming position i, MSB is overall even parity
//    out_valid      output register holds a result
//    out_ready      consumer accepts the result
//    out_data       decoded data (raw when uncorrectable or when correction is disabled)
//    out_err_corr   single error detected (corrected when correct_en)
//    out_err_uncorr uncorrectable error detected
//    out_syndrome   registered Hamming syndrome
//    cnt_corr       saturating count of single-error results
//    cnt_uncorr     saturating count of uncorrectable results
module hamming_secded_decoder #(
   parameter int DATA_W = 4,
   parameter int PAR_W  = 3,
   parameter int CNT_W  = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ena,
   input  logic                          correct_en,
   input  logic                          cnt_clr,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_W+PAR_W:0]         in_code,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_W-1:0]             out_data,
   output logic                          out_err_corr,
   output logic                          out_err_uncorr,
   output logic [PAR_W-1:0]              out_syndrome,
   output logic [CNT_W-1:0]              cnt_corr,
   output logic [CNT_W-1:0]              cnt_uncorr
);
   localparam int N = DATA_W + PAR_W + 1;

   if (2**PAR_W < N) begin : g_bad_params
      $error("hamming_secded_decoder: PAR_W too small for DATA_W");
   end

   // Hamming position holding data bit j: the j-th position in 1..N-1 that is not a power of two.
   function automatic int data_pos(int j);
      int cnt;
      int pos;
      cnt = 0;
      pos = 0;
      for (int i = 1; i < N; i++) begin
         if ((i & (i - 1)) != 0) begin
            if (cnt == j) pos = i;
            cnt++;
         end
      end
      return pos;
   endfunction

   logic [PAR_W-1:0]  syn_c;
   logic              par_c;
   logic              in_range_c;
   logic              corr_c;
   logic              uncorr_c;
   logic [N-1:0]      flip_c;
   logic [N-1:0]      fixed_c;
   logic [DATA_W-1:0] data_c;
   logic              accept;
   logic              pop;

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              corr_q, corr_d;
   logic              uncorr_q, uncorr_d;
   logic [PAR_W-1:0]  syn_q, syn_d;
   logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d;
   logic [CNT_W-1:0]  cnt_uncorr_q, cnt_uncorr_d;

   // Every set bit at position i contributes i itself, so the XOR of positions is the syndrome.
   always_comb begin
      syn_c = '0;
      for (int i = 1; i < N; i++) syn_c = syn_c ^ (in_code[i-1] ? PAR_W'(i) : '0);
   end

   assign par_c      = ^in_code;
   assign in_range_c = int'(syn_c) <= N - 1;
   // Odd parity with s=0 points at the overall parity bit, which still counts as corrected.
   assign corr_c     = par_c & in_range_c;
   assign uncorr_c   = par_c ? !in_range_c : (syn_c != '0);

   for (genvar i = 1; i < N; i++) begin : g_flip
      assign flip_c[i-1] = correct_en & corr_c & (syn_c == PAR_W'(i));
   end
   assign flip_c[N-1] = 1'b0;
   assign fixed_c     = in_code ^ flip_c;

   for (genvar j = 0; j < DATA_W; j++) begin : g_data
      localparam int P = data_pos(j);
      assign data_c[j] = fixed_c[P-1];
   end

   assign in_ready = ena & (!valid_q | out_ready);
   assign accept   = in_valid & in_ready;
   assign pop      = valid_q & out_ready;

   always_comb begin
      valid_d      = accept | (valid_q & !pop);
      data_d       = accept ? data_c : data_q;
      corr_d       = accept ? corr_c : corr_q;
      uncorr_d     = accept ? uncorr_c : uncorr_q;
      syn_d        = accept ? syn_c : syn_q;
      cnt_corr_d   = (ena & cnt_clr) ? '0 :
                     (accept & corr_c & ~&cnt_corr_q) ? cnt_corr_q + CNT_W'(1) : cnt_corr_q;
      cnt_uncorr_d = (ena & cnt_clr) ? '0 :
                     (accept & uncorr_c & ~&cnt_uncorr_q) ? cnt_uncorr_q + CNT_W'(1) : cnt_uncorr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         data_q       <= '0;
         corr_q       <= 1'b0;
         uncorr_q     <= 1'b0;
         syn_q        <= '0;
         cnt_corr_q   <= '0;
         cnt_uncorr_q <= '0;
      end else begin
         valid_q      <= valid_d;
         data_q       <= data_d;
         corr_q       <= corr_d;
         uncorr_q     <= uncorr_d;
         syn_q        <= syn_d;
         cnt_corr_q   <= cnt_corr_d;
         cnt_uncorr_q <= cnt_uncorr_d;
      end
   end

   assign out_valid      = valid_q;
   assign out_data       = data_q;
   assign out_err_corr   = corr_q;
   assign out_err_uncorr = uncorr_q;
   assign out_syndrome   = syn_q;
   assign cnt_corr       = cnt_corr_q;
   assign cnt_uncorr     = cnt_uncorr_q;
endmodule

// File: tb/tb_hamming_secded_decoder.sv
// tb_hamming_secded_decoder: directed and randomized checks of the SECDED decoder against a codeword-level model
module tb_hamming_secded_decoder;
   localparam int AD = 4, AP = 3, AC = 2, AN = AD + AP + 1;
   localparam int BD = 11, BP = 4, BC = 8, BN = BD + BP + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic a_ena, a_ce, a_clr, a_iv, a_ir, a_ov, a_or, a_ec, a_eu;
   logic [AN-1:0] a_code;
   logic [AD-1:0] a_od;
   logic [AP-1:0] a_syn;
   logic [AC-1:0] a_cc, a_cu;

   logic b_ena, b_ce, b_clr, b_iv, b_ir, b_ov, b_or, b_ec, b_eu;
   logic [BN-1:0] b_code;
   logic [BD-1:0] b_od;
   logic [BP-1:0] b_syn;
   logic [BC-1:0] b_cc, b_cu;

   hamming_secded_decoder #(.DATA_W(AD), .PAR_W(AP), .CNT_W(AC)) dut_a (
      .clk(clk), .rst_n(rst_n), .ena(a_ena), .correct_en(a_ce), .cnt_clr(a_clr),
      .in_valid(a_iv), .in_ready(a_ir), .in_code(a_code),
      .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
      .out_err_corr(a_ec), .out_err_uncorr(a_eu), .out_syndrome(a_syn),
      .cnt_corr(a_cc), .cnt_uncorr(a_cu));

   hamming_secded_decoder #(.DATA_W(BD), .PAR_W(BP), .CNT_W(BC)) dut_b (
      .clk(clk), .rst_n(rst_n), .ena(b_ena), .correct_en(b_ce), .cnt_clr(b_clr),
      .in_valid(b_iv), .in_ready(b_ir), .in_code(b_code),
      .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
      .out_err_corr(b_ec), .out_err_uncorr(b_eu), .out_syndrome(b_syn),
      .cnt_corr(b_cc), .cnt_uncorr(b_cu));

   int nchk = 0;
   int nerr = 0;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] encode(int dw, int pw, logic [63:0] d);
      logic [63:0] c;
      int n, j;
      logic p;
      n = dw + pw + 1;
      c = '0;
      j = 0;
      for (int i = 1; i < n; i++)
         if ((i & (i - 1)) != 0 && j < dw) begin
            c[i-1] = d[j];
            j++;
         end
      for (int k = 0; k < pw; k++)
         if ((1 << k) < n) begin
            p = 1'b0;
            for (int i = 1; i < n; i++)
               if (((i >> k) & 1) == 1 && i != (1 << k)) p ^= c[i-1];
            c[(1 << k) - 1] = p;
         end
      c[n-1] = ^c;
      return c;
   endfunction

   function automatic logic [63:0] extract(int dw, int n, logic [63:0] c);
      logic [63:0] d;
      int j;
      d = '0;
      j = 0;
      for (int i = 1; i < n; i++)
         if ((i & (i - 1)) != 0 && j < dw) begin
            d[j] = c[i-1];
            j++;
         end
      return d;
   endfunction

   // Position 0 names the overall parity bit (codeword MSB).
   function automatic logic [63:0] corrupt(int dw, int pw, logic [63:0] d, int nf, int pa, int pb);
      logic [63:0] c;
      int n;
      n = dw + pw + 1;
      c = encode(dw, pw, d);
      if (nf >= 1) c[pa == 0 ? n - 1 : pa - 1] ^= 1'b1;
      if (nf >= 2) c[pb == 0 ? n - 1 : pb - 1] ^= 1'b1;
      return c;
   endfunction

   typedef struct {
      logic [63:0] data;
      logic        ec;
      logic        eu;
      logic [63:0] syn;
   } res_t;

   function automatic res_t expect_res(int dw, int pw, logic [63:0] d, int nf, int pa, int pb, logic ce);
      res_t r;
      r.ec   = nf == 1;
      r.eu   = nf == 2;
      r.syn  = nf == 0 ? 64'd0 : nf == 1 ? 64'(pa) : 64'(pa ^ pb);
      r.data = (nf == 1 && ce) ? d : extract(dw, dw + pw + 1, corrupt(dw, pw, d, nf, pa, pb));
      return r;
   endfunction

   task automatic a_send(logic [AN-1:0] c, logic ce);
      a_code = c;
      a_ce   = ce;
      a_iv   = 1'b1;
      a_or   = 1'b1;
      @(posedge clk);
      #1;
      a_iv = 1'b0;
   endtask

   res_t        aq[$];
   res_t        r;
   int          mc, mu, nf, pa, pb;
   logic        acc, pop, exp_ir;
   logic [63:0] d, t;

   initial begin
      a_ena = 1'b1; a_ce = 1'b1; a_clr = 1'b0; a_iv = 1'b0; a_or = 1'b1; a_code = '0;
      b_ena = 1'b1; b_ce = 1'b1; b_clr = 1'b0; b_iv = 1'b0; b_or = 1'b1; b_code = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ov", a_ov, 0);
      chk("rst_od", a_od, 0);
      chk("rst_flags", {a_ec, a_eu}, 0);
      chk("rst_syn", a_syn, 0);
      chk("rst_cnt", {a_cc, a_cu}, 0);
      chk("rst_b_ov", b_ov, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      a_send(8'h55, 1'b1);
      chk("clean_ov", a_ov, 1);
      chk("clean_od", a_od, 4'hB);
      chk("clean_flags", {a_ec, a_eu}, 0);
      chk("clean_syn", a_syn, 0);
      a_send(8'h45, 1'b1);
      chk("fix_od", a_od, 4'hB);
      chk("fix_ec", {a_ec, a_eu}, 2'b10);
      chk("fix_syn", a_syn, 3'b101);
      chk("fix_cc", a_cc, 1);
      a_send(8'h45, 1'b0);
      chk("det_od", a_od, 4'h9);
      chk("det_ec", {a_ec, a_eu}, 2'b10);
      chk("det_cc", a_cc, 2);
      a_send(8'hD5, 1'b1);
      chk("par_od", a_od, 4'hB);
      chk("par_ec", {a_ec, a_eu}, 2'b10);
      chk("par_syn", a_syn, 0);
      a_send(8'h56, 1'b1);
      chk("dbl_flags", {a_ec, a_eu}, 2'b01);
      chk("dbl_syn", a_syn, 3'b011);
      chk("dbl_od", a_od, 4'hB);
      chk("dbl_cu", a_cu, 1);
      a_send(8'h45, 1'b1);
      a_send(8'h45, 1'b1);
      chk("sat_cc", a_cc, 3);
      a_clr = 1'b1;
      a_send(8'h45, 1'b1);
      a_clr = 1'b0;
      chk("clr_cc", a_cc, 0);
      chk("clr_cu", a_cu, 0);
      @(posedge clk);
      #1;
      chk("pop_ov", a_ov, 0);

      t = encode(AD, AP, 64'h6);
      a_or = 1'b0; a_code = 8'h55; a_iv = 1'b1;
      @(posedge clk);
      #1;
      a_code = t[AN-1:0];
      for (int i = 0; i < 3; i++) begin
         chk("bp_ir", a_ir, 0);
         chk("bp_ov", a_ov, 1);
         chk("bp_od", a_od, 4'hB);
         @(posedge clk);
         #1;
      end
      a_or = 1'b1;
      @(posedge clk);
      #1;
      a_iv = 1'b0;
      chk("bp_second_ov", a_ov, 1);
      chk("bp_second_od", a_od, 4'h6);
      @(posedge clk);
      #1;
      chk("bp_drain_ov", a_ov, 0);

      a_code = 8'h45; a_iv = 1'b1; a_or = 1'b0;
      @(posedge clk);
      #1;
      a_iv = 1'b0;
      chk("pre_rst_ov", a_ov, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ov", a_ov, 0);
      chk("arst_od", a_od, 0);
      chk("arst_flags", {a_ec, a_eu}, 0);
      chk("arst_syn", a_syn, 0);
      chk("arst_cnt", {a_cc, a_cu}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      mc = 0;
      mu = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         a_ena = ($urandom % 8) != 0;
         a_iv  = $urandom % 2;
         a_or  = ($urandom % 3) != 0;
         a_ce  = $urandom % 2;
         a_clr = a_ena && ($urandom % 25) == 0;
         d  = 64'($urandom % 16);
         nf = $urandom % 3;
         pa = $urandom_range(0, AN - 1);
         pb = (pa + $urandom_range(1, AN - 1)) % AN;
         t  = corrupt(AD, AP, d, nf, pa, pb);
         a_code = t[AN-1:0];
         #3;
         exp_ir = a_ena && (aq.size() == 0 || a_or);
         chk("rnd_ir", a_ir, exp_ir);
         acc = a_iv && exp_ir;
         pop = aq.size() != 0 && a_or;
         if (aq.size() != 0) begin
            chk("rnd_od", a_od, aq[0].data);
            chk("rnd_flags", {a_ec, a_eu}, {aq[0].ec, aq[0].eu});
            chk("rnd_syn", a_syn, aq[0].syn);
         end
         @(posedge clk);
         #1;
         if (pop) void'(aq.pop_front());
         if (acc) aq.push_back(expect_res(AD, AP, d, nf, pa, pb, a_ce));
         if (a_ena && a_clr) begin
            mc = 0;
            mu = 0;
         end else if (acc) begin
            if (nf == 1 && mc < 3) mc++;
            if (nf == 2 && mu < 3) mu++;
         end
         chk("rnd_ov", a_ov, aq.size() != 0);
         chk("rnd_cc", a_cc, mc);
         chk("rnd_cu", a_cu, mu);
      end
      a_iv = 1'b0;
      a_clr = 1'b0;

      d = 64'($urandom % 2048);
      b_iv = 1'b1;
      for (int p = 0; p < BN; p++) begin
         t = corrupt(BD, BP, d, 1, p, 0);
         b_code = t[BN-1:0];
         @(posedge clk);
         #1;
         chk("b_single_od", b_od, d);
         chk("b_single_flags", {b_ec, b_eu}, 2'b10);
         chk("b_single_syn", b_syn, p);
      end
      for (int p = 0; p < BN; p++)
         for (int q = p + 1; q < BN; q++) begin
            t = corrupt(BD, BP, d, 2, p, q);
            b_code = t[BN-1:0];
            r = expect_res(BD, BP, d, 2, p, q, 1'b1);
            @(posedge clk);
            #1;
            chk("b_double_flags", {b_ec, b_eu}, 2'b01);
            chk("b_double_od", b_od, r.data);
            chk("b_double_syn", b_syn, r.syn);
         end
      b_iv = 1'b0;
      @(posedge clk);
      #1;
      chk("b_cc", b_cc, BN);
      chk("b_cu", b_cu, 8'd120);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
